// File: rtl/vinsn_tracker.sv
// In-flight vector instruction tracker: allocates IDs at issue, queues commit
// events into an in-order response FIFO, frees IDs on response, and drains on request.
module vinsn_tracker #(
    parameter int unsigned InsnIDNum   = 8,
    parameter int unsigned InsnIDWidth = $clog2(InsnIDNum),
    parameter int unsigned CntWidth    = $clog2(InsnIDNum + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    output logic [InsnIDWidth-1:0] issue_id_o,
    input  logic                   done_i,
    input  logic [InsnIDWidth-1:0] done_insn_id_i,
    input  logic                   done_illegal_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [InsnIDWidth-1:0] resp_id_o,
    output logic                   resp_illegal_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic [CntWidth-1:0]    outstanding_cnt_o,
    output logic                   idle_o,
    output logic                   err_o
);

    // Handshakes: a transfer happens on a cycle where valid && ready; ready
    // never looks at valid, and done_i has no ready because the commit side
    // cannot stall.
    typedef enum logic [1:0] {
        NORMAL,
        DRAIN,
        DRAINED
    } state_e;

    state_e                   state_q;
    logic                     flush_done_q;
    logic [InsnIDNum-1:0]     alloc_q, alloc_d;
    logic [InsnIDNum-1:0]     pend_q, pend_d;
    logic [InsnIDWidth-1:0]   fifo_id_q [InsnIDNum];
    logic [InsnIDNum-1:0]     fifo_ill_q;
    logic [InsnIDWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]      fifo_cnt_q, out_cnt_q;
    logic                     err_q;

    logic fire_issue, fire_pop, done_ok, done_bad;

    always_comb begin
        issue_id_o = '0;
        for (int i = InsnIDNum - 1; i >= 0; i--) begin
            if (!alloc_q[i]) issue_id_o = InsnIDWidth'(i);
        end
    end

    assign issue_ready_o     = !(&alloc_q) && (state_q == NORMAL);
    assign fire_issue        = issue_valid_i && issue_ready_o;
    assign done_ok           = done_i && pend_q[done_insn_id_i];
    assign done_bad          = done_i && !pend_q[done_insn_id_i];
    assign resp_valid_o      = (fifo_cnt_q != '0);
    assign fire_pop          = resp_valid_o && resp_ready_i;
    assign resp_id_o         = resp_valid_o ? fifo_id_q[rd_ptr_q] : '0;
    assign resp_illegal_o    = resp_valid_o && fifo_ill_q[rd_ptr_q];
    assign outstanding_cnt_o = out_cnt_q;
    assign idle_o            = (out_cnt_q == '0) && (fifo_cnt_q == '0);
    assign err_o             = err_q;
    assign flush_done_o      = flush_done_q;

    // Issue, done and pop always touch distinct IDs, so they compose freely.
    always_comb begin
        alloc_d = alloc_q;
        pend_d  = pend_q;
        if (fire_issue) begin
            alloc_d[issue_id_o] = 1'b1;
            pend_d[issue_id_o]  = 1'b1;
        end
        if (done_ok) pend_d[done_insn_id_i] = 1'b0;
        if (fire_pop) alloc_d[resp_id_o] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q    <= '0;
            pend_q     <= '0;
            fifo_ill_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < InsnIDNum; i++) fifo_id_q[i] <= '0;
        end else begin
            alloc_q <= alloc_d;
            pend_q  <= pend_d;
            if (done_bad) err_q <= 1'b1;
            if (done_ok) begin
                fifo_id_q[wr_ptr_q]  <= done_insn_id_i;
                fifo_ill_q[wr_ptr_q] <= done_illegal_i;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (fire_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({done_ok, fire_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            case ({fire_issue, fire_pop})
                2'b10:   out_cnt_q <= out_cnt_q + CntWidth'(1);
                2'b01:   out_cnt_q <= out_cnt_q - CntWidth'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Drain FSM; flush_done_q is set on entry to DRAINED so it spans exactly that state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= NORMAL;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                NORMAL: begin
                    if (flush_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (idle_o) begin
                        state_q      <= DRAINED;
                        flush_done_q <= 1'b1;
                    end
                end
                DRAINED: state_q <= NORMAL;
                default: state_q <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_vinsn_tracker.sv
// Directed bench for vinsn_tracker: a set/queue model is checked against the DUT
// every cycle, and literal expectations pin key points of each scenario.
module tb_vinsn_tracker;

    localparam int N = 8;
    localparam int W = 3;
    localparam int C = 4;

    logic         clk;
    logic         rst_n;
    logic         issue_valid;
    logic         issue_ready;
    logic [W-1:0] issue_id;
    logic         done;
    logic [W-1:0] done_id;
    logic         done_ill;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_id;
    logic         resp_ill;
    logic         flush;
    logic         flush_done;
    logic [C-1:0] out_cnt;
    logic         idle;
    logic         err;

    vinsn_tracker #(.InsnIDNum(N)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_id_o        (issue_id),
        .done_i            (done),
        .done_insn_id_i    (done_id),
        .done_illegal_i    (done_ill),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_id_o         (resp_id),
        .resp_illegal_o    (resp_ill),
        .flush_i           (flush),
        .flush_done_o      (flush_done),
        .outstanding_cnt_o (out_cnt),
        .idle_o            (idle),
        .err_o             (err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    // behavioural model: sets of allocated / awaiting-done IDs, response queue, drain phase
    bit m_alloc [N];
    bit m_pend  [N];
    int q_id  [$];
    int q_ill [$];
    bit m_err;
    int m_phase;  // 0 normal, 1 draining, 2 drained

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alloc[i]);
        return c;
    endfunction

    function automatic int m_lowfree();
        for (int i = 0; i < N; i++) if (!m_alloc[i]) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
        return (m_count() < N) && (m_phase == 0);
    endfunction

    function automatic bit m_idle();
        return (m_count() == 0) && (q_id.size() == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alloc[i] = 1'b0;
            m_pend[i]  = 1'b0;
        end
        q_id.delete();
        q_ill.delete();
        m_err   = 1'b0;
        m_phase = 0;
    endtask

    task automatic model_step();
        bit rdy, was_idle, pop;
        int fid, pid;
        rdy      = m_ready();
        fid      = m_lowfree();
        was_idle = m_idle();
        pop      = (q_id.size() > 0) && resp_ready;
        pid      = pop ? q_id[0] : 0;
        if (done) begin
            if (m_pend[int'(done_id)]) begin
                m_pend[int'(done_id)] = 1'b0;
                q_id.push_back(int'(done_id));
                q_ill.push_back(int'(done_ill));
            end else begin
                m_err = 1'b1;
            end
        end
        if (issue_valid && rdy) begin
            m_alloc[fid] = 1'b1;
            m_pend[fid]  = 1'b1;
        end
        if (pop) begin
            m_alloc[pid] = 1'b0;
            void'(q_id.pop_front());
            void'(q_ill.pop_front());
        end
        case (m_phase)
            0:       if (flush) m_phase = 1;
            1:       if (was_idle) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    // compare process: every negedge while out of reset
    always @(negedge clk) begin
        if (chk_en) begin
            check("issue_ready", int'(issue_ready), int'(m_ready()));
            if (m_ready()) check("issue_id", int'(issue_id), m_lowfree());
            check("resp_valid", int'(resp_valid), int'(q_id.size() > 0));
            if (q_id.size() > 0) begin
                check("resp_id", int'(resp_id), q_id[0]);
                check("resp_illegal", int'(resp_ill), q_ill[0]);
            end
            check("outstanding", int'(out_cnt), m_count());
            check("idle", int'(idle), int'(m_idle()));
            check("err", int'(err), int'(m_err));
            check("flush_done", int'(flush_done), int'(m_phase == 2));
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic go(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        done        = 1'b0;
        done_id     = '0;
        done_ill    = 1'b0;
        resp_ready  = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_issue_ready"}, int'(issue_ready), 1);
        check({tag, "_issue_id"}, int'(issue_id), 0);
        check({tag, "_resp_valid"}, int'(resp_valid), 0);
        check({tag, "_resp_id"}, int'(resp_id), 0);
        check({tag, "_resp_ill"}, int'(resp_ill), 0);
        check({tag, "_outstanding"}, int'(out_cnt), 0);
        check({tag, "_idle"}, int'(idle), 1);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_flush_done"}, int'(flush_done), 0);
    endtask

    int ord_id  [4] = '{2, 0, 3, 1};
    int ord_ill [4] = '{0, 1, 0, 0};

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // three back-to-back issues
        issue_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("b2b_id", int'(issue_id), k);
            cycle();
        end
        issue_valid = 1'b0;
        check("b2b_cnt", int'(out_cnt), 3);
        check("b2b_idle", int'(idle), 0);

        // fill all IDs, then free id 5 and reissue it
        issue_valid = 1'b1;
        for (int k = 3; k < N; k++) begin
            check("fill_id", int'(issue_id), k);
            cycle();
        end
        check("full_ready", int'(issue_ready), 0);
        cycle();
        done       = 1'b1;
        done_id    = 3'd5;
        resp_ready = 1'b1;
        cycle();
        done = 1'b0;
        check("d5_resp_valid", int'(resp_valid), 1);
        check("d5_resp_id", int'(resp_id), 5);
        check("d5_ready_p1", int'(issue_ready), 0);
        cycle();
        check("d5_ready_p2", int'(issue_ready), 1);
        check("d5_reissue_id", int'(issue_id), 5);
        cycle();
        issue_valid = 1'b0;
        check("refill_cnt", int'(out_cnt), 8);
        for (int k = 0; k < N; k++) begin
            done    = 1'b1;
            done_id = W'(k);
            cycle();
        end
        done = 1'b0;
        go(3);
        check("empty_idle", int'(idle), 1);

        // out-of-order completion with response held off for 6 cycles
        resp_ready  = 1'b0;
        issue_valid = 1'b1;
        go(4);
        issue_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            done     = 1'b1;
            done_id  = W'(ord_id[j]);
            done_ill = ord_ill[j][0];
            cycle();
        end
        done     = 1'b0;
        done_ill = 1'b0;
        go(2);
        check("ooo_cnt", int'(out_cnt), 4);
        check("ooo_head", int'(resp_id), 2);
        resp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("ooo_resp_id", int'(resp_id), ord_id[j]);
            check("ooo_resp_ill", int'(resp_ill), ord_ill[j]);
            cycle();
        end
        go(2);
        check("ooo_idle", int'(idle), 1);

        // simultaneous issue + done + pop
        resp_ready  = 1'b0;
        issue_valid = 1'b1;
        go(4);
        issue_valid = 1'b0;
        done        = 1'b1;
        done_id     = 3'd0;
        cycle();
        done = 1'b0;
        check("sim_head0", int'(resp_id), 0);
        issue_valid = 1'b1;
        done        = 1'b1;
        done_id     = 3'd1;
        resp_ready  = 1'b1;
        check("sim_issue_id", int'(issue_id), 4);
        cycle();
        clear_inputs();
        check("sim_cnt", int'(out_cnt), 4);
        check("sim_resp_valid", int'(resp_valid), 1);
        check("sim_resp_id", int'(resp_id), 1);
        check("sim_next_id", int'(issue_id), 0);

        // drain with two outstanding
        resp_ready = 1'b1;
        done       = 1'b1;
        done_id    = 3'd2;
        cycle();
        done = 1'b0;
        cycle();
        check("drn_cnt", int'(out_cnt), 2);
        check("drn_resp_valid", int'(resp_valid), 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("drn_ready", int'(issue_ready), 0);
        done    = 1'b1;
        done_id = 3'd3;
        cycle();
        done_id = 3'd4;
        cycle();
        done = 1'b0;
        check("drn_last_resp", int'(resp_id), 4);
        cycle();
        check("drn_fd_p1", int'(flush_done), 0);
        cycle();
        check("drn_fd_p2", int'(flush_done), 1);
        cycle();
        check("drn_fd_p3", int'(flush_done), 0);
        check("drn_ready_back", int'(issue_ready), 1);

        // flush while idle
        flush = 1'b1;
        check("fi_fd_0", int'(flush_done), 0);
        cycle();
        flush = 1'b0;
        check("fi_ready", int'(issue_ready), 0);
        check("fi_fd_1", int'(flush_done), 0);
        cycle();
        check("fi_fd_2", int'(flush_done), 1);
        cycle();
        check("fi_fd_3", int'(flush_done), 0);

        // protocol error on a never-issued ID
        check("err_before", int'(err), 0);
        done    = 1'b1;
        done_id = 3'd7;
        cycle();
        done = 1'b0;
        check("err_set", int'(err), 1);
        check("err_no_resp", int'(resp_valid), 0);
        go(3);
        check("err_sticky", int'(err), 1);

        // asynchronous reset mid-traffic
        resp_ready  = 1'b0;
        issue_valid = 1'b1;
        go(2);
        issue_valid = 1'b0;
        done        = 1'b1;
        done_id     = 3'd0;
        cycle();
        clear_inputs();
        check("pre_rst_valid", int'(resp_valid), 1);
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        go(2);
        check("post_rst_ready", int'(issue_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

endmodule
